uart_tx: RTL and testbench

UART transmitter, the counterpart to the team's uart_rx. It serialises one parallel word per frame onto oTx: start bit, data bits LSB first, optional parity bit, then 1 or 2 stop bits. Frame format parameters match uart_rx so a tx/rx pair with identical parameters loops back cleanly. It sits between the keyboard/command logic and the serial pin, using a valid/ready handshake plus CTS flow control.

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_tx_baud.sv | 31 +++
 rtl/uart_tx.sv | 132 +++++++++++++
 tb/tb_uart_tx.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, parity modes and the
// parity helper used by both uart_tx and uart_rx.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam logic [1:0] P_NONE = 2'd0;
    localparam logic [1:0] P_ODD  = 2'd1;
    localparam logic [1:0] P_EVE  = 2'd2;

    // Narrow words are zero-extended, which leaves the xor unchanged.
    function automatic logic parity_calc(
        input logic [7:0] data,
        input logic [1:0] ptype
    );
        case (ptype)
            P_ODD:   return ~^data;
            P_EVE:   return ^data;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_tx_baud.sv
// Restartable bit-period divider; oBit_end marks the last clock of a bit.
// Held at zero while iRestart is high so frames align to the accept edge.
module uart_tx_baud
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic iClk,
    input  logic iRst,
    input  logic iRestart,
    output logic oBit_end
);

    localparam int W = $clog2(CLKS_PER_BIT);
    localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            cnt <= '0;
        end else if (iRestart || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

    assign oBit_end = (cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, LSB-first data, optional parity, 1-2 stop bits.
// Valid/ready handshake with CTS gating only the start of a frame.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ    = 50_000_000,
    parameter int BAUD_RATE   = 9600,
    parameter int BIT_LENGHT  = 8,
    parameter int PARITY_TYPE = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                  iClk,
    input  logic                  iRst,
    input  logic [BIT_LENGHT-1:0] iData,
    input  logic                  iValid,
    output logic                  oReady,
    input  logic                  iCTS,
    output logic                  oTx,
    output logic                  oBusy,
    output logic                  oDone
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam bit HAS_PAR =
        (PARITY_TYPE == 1) || (PARITY_TYPE == 2);
    localparam logic [2:0] LAST_IDX = 3'(BIT_LENGHT - 1);
    localparam logic LAST_STOP = 1'(STOP_BITS - 1);

    state_t                  state, state_d;
    logic [BIT_LENGHT-1:0]   sh, sh_d;
    logic [2:0]              idx, idx_d;
    logic                    stop_cnt, stop_d;
    logic                    par, par_d;
    logic                    tx_q, tx_d;
    logic                    done_q, done_d;
    logic                    bit_end;

    // Counter sits at zero whenever idle, including the accept edge.
    uart_tx_baud #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .iClk    (iClk),
        .iRst    (iRst),
        .iRestart(state == IDLE),
        .oBit_end(bit_end)
    );

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            state    <= IDLE;
            sh       <= '0;
            idx      <= '0;
            stop_cnt <= 1'b0;
            par      <= 1'b0;
            tx_q     <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state    <= state_d;
            sh       <= sh_d;
            idx      <= idx_d;
            stop_cnt <= stop_d;
            par      <= par_d;
            tx_q     <= tx_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d = state;
        sh_d    = sh;
        idx_d   = idx;
        stop_d  = stop_cnt;
        par_d   = par;
        done_d  = 1'b0;
        unique case (state)
            IDLE: begin
                if (iValid && iCTS) begin
                    state_d = START;
                    sh_d    = iData;
                    par_d   = parity_calc(8'(iData),
                                          2'(PARITY_TYPE));
                    idx_d   = '0;
                    stop_d  = 1'b0;
                end
            end
            START: begin
                if (bit_end) state_d = DATA;
            end
            DATA: begin
                if (bit_end) begin
                    if (idx == LAST_IDX) begin
                        state_d = HAS_PAR ? PARITY : STOP;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) state_d = STOP;
            end
            STOP: begin
                if (bit_end) begin
                    if (stop_cnt == LAST_STOP) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        stop_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Line level is registered from the next state, so it moves with it.
    always_comb begin
        tx_d = 1'b1;
        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = sh_d[idx_d];
            PARITY:  tx_d = par_d;
            default: tx_d = 1'b1;
        endcase
    end

    assign oTx    = tx_q;
    assign oDone  = done_q;
    assign oReady = (state == IDLE);
    assign oBusy  = (state != IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: four parameter variants on one clock,
// frame vectors from a table plus CTS, back-to-back and reset sequences.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data;
    logic [3:0] valid;
    logic       cts;
    logic [3:0] ready, tx, busy, done;

    int total = 0;
    int pass  = 0;

    always #5 clk = ~clk;

    uart_tx #(.CLK_FREQ(160000), .BAUD_RATE(10000), .BIT_LENGHT(8),
              .PARITY_TYPE(0), .STOP_BITS(1)) u0 (
        .iClk(clk), .iRst(rst), .iData(data), .iValid(valid[0]),
        .oReady(ready[0]), .iCTS(cts), .oTx(tx[0]),
        .oBusy(busy[0]), .oDone(done[0]));

    uart_tx #(.CLK_FREQ(160000), .BAUD_RATE(10000), .BIT_LENGHT(8),
              .PARITY_TYPE(1), .STOP_BITS(1)) u1 (
        .iClk(clk), .iRst(rst), .iData(data), .iValid(valid[1]),
        .oReady(ready[1]), .iCTS(cts), .oTx(tx[1]),
        .oBusy(busy[1]), .oDone(done[1]));

    uart_tx #(.CLK_FREQ(160000), .BAUD_RATE(10000), .BIT_LENGHT(8),
              .PARITY_TYPE(2), .STOP_BITS(1)) u2 (
        .iClk(clk), .iRst(rst), .iData(data), .iValid(valid[2]),
        .oReady(ready[2]), .iCTS(cts), .oTx(tx[2]),
        .oBusy(busy[2]), .oDone(done[2]));

    uart_tx #(.CLK_FREQ(160000), .BAUD_RATE(10000), .BIT_LENGHT(8),
              .PARITY_TYPE(0), .STOP_BITS(2)) u3 (
        .iClk(clk), .iRst(rst), .iData(data), .iValid(valid[3]),
        .oReady(ready[3]), .iCTS(cts), .oTx(tx[3]),
        .oBusy(busy[3]), .oDone(done[3]));

    // e[i] is the i-th bit on the wire: {stop(s), parity, data, start}
    typedef struct {
        int          k;
        logic [7:0]  d;
        logic [11:0] e;
        int          nb;
    } vec_t;

    vec_t tv[9];

    task automatic chk(input string n, input logic [31:0] a,
                       input logic [31:0] x);
        total++;
        if (a === x) pass++;
        else $display("FAIL %s: got %0h want %0h", n, a, x);
    endtask

    task automatic accept(input int k, input logic [7:0] d);
        data     = d;
        valid[k] = 1'b1;
        cts      = 1'b1;
        @(negedge clk);
        valid[k] = 1'b0;
        data     = ~d;
    endtask

    // Entered in the first cycle after the accept edge.
    task automatic body(input int k, input logic [7:0] d,
                        input logic [11:0] e, input int nb,
                        input bit chain, input logic [7:0] d2);
        logic       bad;
        logic       ctl_bad;
        logic [7:0] dec;
        ctl_bad = 1'b0;
        dec     = '0;
        for (int b = 0; b < nb; b++) begin
            bad = 1'b0;
            for (int c = 0; c < 16; c++) begin
                if (tx[k] !== e[b]) bad = 1'b1;
                if (ready[k] !== 1'b0 || busy[k] !== 1'b1 ||
                    done[k] !== 1'b0) ctl_bad = 1'b1;
                if (c == 8 && b >= 1 && b <= 8) dec[b-1] = tx[k];
                @(negedge clk);
            end
            chk($sformatf("u%0d %02h bit%0d", k, d, b),
                32'(bad), 32'd0);
        end
        chk($sformatf("u%0d %02h ctl in frame", k, d),
            32'(ctl_bad), 32'd0);
        chk($sformatf("u%0d %02h decoded", k, d), 32'(dec), 32'(d));
        chk($sformatf("u%0d %02h done", k, d), 32'(done[k]), 32'd1);
        chk($sformatf("u%0d %02h ready at done", k, d),
            32'(ready[k]), 32'd1);
        chk($sformatf("u%0d %02h idle line", k, d), 32'(tx[k]), 32'd1);
        if (chain) begin
            data     = d2;
            valid[k] = 1'b1;
        end
        @(negedge clk);
        valid[k] = 1'b0;
        chk($sformatf("u%0d %02h done width", k, d),
            32'(done[k]), 32'd0);
    endtask

    initial begin
        logic bad;

        tv[0] = '{0, 8'hA5, 12'b00_1_10100101_0, 10};
        tv[1] = '{1, 8'h03, 12'b0_1_1_00000011_0, 11};
        tv[2] = '{2, 8'h03, 12'b0_1_0_00000011_0, 11};
        tv[3] = '{0, 8'h00, 12'b00_1_00000000_0, 10};
        tv[4] = '{1, 8'h55, 12'b0_1_1_01010101_0, 11};
        tv[5] = '{2, 8'h80, 12'b0_1_1_10000000_0, 11};
        tv[6] = '{2, 8'hFF, 12'b0_1_0_11111111_0, 11};
        tv[7] = '{1, 8'hFF, 12'b0_1_1_11111111_0, 11};
        tv[8] = '{3, 8'hA5, 12'b0_11_10100101_0, 11};

        rst   = 1'b0;
        valid = '0;
        cts   = 1'b1;
        data  = '0;
        repeat (3) @(negedge clk);
        chk("reset tx", 32'(tx), 32'hF);
        chk("reset ready", 32'(ready), 32'hF);
        chk("reset busy", 32'(busy), 32'h0);
        chk("reset done", 32'(done), 32'h0);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            accept(tv[i].k, tv[i].d);
            body(tv[i].k, tv[i].d, tv[i].e, tv[i].nb, 1'b0, 8'h00);
        end

        // Two stop bits, then a word taken in the done cycle.
        accept(3, 8'hFF);
        body(3, 8'hFF, 12'b0_11_11111111_0, 11, 1'b1, 8'h5A);
        body(3, 8'h5A, 12'b0_11_01011010_0, 11, 1'b0, 8'h00);

        // CTS low holds off the accept; dropping it mid-frame does not.
        cts      = 1'b0;
        data     = 8'hA5;
        valid[0] = 1'b1;
        bad      = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (tx[0] !== 1'b1 || ready[0] !== 1'b1 ||
                busy[0] !== 1'b0) bad = 1'b1;
        end
        chk("cts hold-off", 32'(bad), 32'd0);
        cts = 1'b1;
        @(negedge clk);
        valid[0] = 1'b0;
        data     = 8'h00;
        cts      = 1'b0;
        body(0, 8'hA5, 12'b00_1_10100101_0, 10, 1'b0, 8'h00);
        cts = 1'b1;

        // Reset during data bit 3 aborts the frame with no done pulse.
        accept(0, 8'h00);
        repeat (69) @(negedge clk);
        chk("mid bit3 level", 32'(tx[0]), 32'd0);
        rst = 1'b0;
        #1;
        chk("abort tx", 32'(tx[0]), 32'd1);
        chk("abort ready", 32'(ready[0]), 32'd1);
        chk("abort busy", 32'(busy[0]), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        bad = 1'b0;
        repeat (200) begin
            @(negedge clk);
            if (done[0] !== 1'b0 || tx[0] !== 1'b1) bad = 1'b1;
        end
        chk("no done after abort", 32'(bad), 32'd0);
        accept(0, 8'h5A);
        body(0, 8'h5A, 12'b00_1_01011010_0, 10, 1'b0, 8'h00);

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

endmodule
